// File: rtl/lsu_dccm_wbuf_mem_pkg.sv
// rtl/lsu_dccm_wbuf_mem_pkg.sv - shared LSU DCCM geometry, write-buffer entry type and address helpers
package lsu_dccm_wbuf_mem_pkg;

    localparam int LSU_DCCM_BITS    = 16;
    localparam int LSU_BANK_BITS    = 2;
    localparam int LSU_NUM_BANKS    = 1 << LSU_BANK_BITS;
    localparam int LSU_WIDTH_BITS   = 2;
    localparam int LSU_FDATA_WIDTH  = 39;
    localparam int LSU_INDEX_BITS   = LSU_DCCM_BITS - LSU_WIDTH_BITS - LSU_BANK_BITS;
    localparam int LSU_WORD_BITS    = LSU_DCCM_BITS - LSU_WIDTH_BITS;

    typedef logic [LSU_DCCM_BITS-1:0]   dccm_addr_t;
    typedef logic [LSU_FDATA_WIDTH-1:0] dccm_data_t;

    typedef struct packed {
        dccm_addr_t addr_lo;
        dccm_addr_t addr_hi;
        dccm_data_t data_lo;
        dccm_data_t data_hi;
    } wb_entry_t;

    function automatic logic [LSU_BANK_BITS-1:0] dccm_bank(input dccm_addr_t addr);
        return addr[LSU_WIDTH_BITS +: LSU_BANK_BITS];
    endfunction

    function automatic logic [LSU_INDEX_BITS-1:0] dccm_index(input dccm_addr_t addr);
        return addr[LSU_DCCM_BITS-1:LSU_WIDTH_BITS+LSU_BANK_BITS];
    endfunction

    function automatic logic [LSU_WORD_BITS-1:0] dccm_word(input dccm_addr_t addr);
        return addr[LSU_DCCM_BITS-1:LSU_WIDTH_BITS];
    endfunction

endpackage

// File: rtl/lsu_dccm_wbuf_mem_bank.sv
// rtl/lsu_dccm_wbuf_mem_bank.sv - one DCCM bank: synchronous-read single-port RAM
module lsu_dccm_bank #(
    parameter int DEPTH  = 4096,
    parameter int WIDTH  = 39,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  wdata,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // rdata holds its last read value on write or idle cycles
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/lsu_dccm_wbuf_mem.sv
// rtl/lsu_dccm_wbuf_mem.sv - banked DCCM with posted-write buffer, read priority and store forwarding
module lsu_dccm_wbuf_mem
    import lsu_dccm_wbuf_mem_pkg::*;
#(
    parameter int DCCM_BITS        = LSU_DCCM_BITS,
    parameter int DCCM_NUM_BANKS   = LSU_NUM_BANKS,
    parameter int DCCM_BANK_BITS   = LSU_BANK_BITS,
    parameter int DCCM_WIDTH_BITS  = LSU_WIDTH_BITS,
    parameter int DCCM_FDATA_WIDTH = LSU_FDATA_WIDTH,
    parameter int WB_DEPTH         = 4,
    parameter int WB_STALL_MAX     = 4
) (
    input  logic                        clk,
    input  logic                        rst_l,
    input  logic                        wr_valid,
    output logic                        wr_ready,
    input  logic [DCCM_BITS-1:0]        wr_addr_lo,
    input  logic [DCCM_BITS-1:0]        wr_addr_hi,
    input  logic [DCCM_FDATA_WIDTH-1:0] wr_data_lo,
    input  logic [DCCM_FDATA_WIDTH-1:0] wr_data_hi,
    input  logic                        rd_valid,
    output logic                        rd_ready,
    input  logic [DCCM_BITS-1:0]        rd_addr_lo,
    input  logic [DCCM_BITS-1:0]        rd_addr_hi,
    output logic                        rd_data_valid,
    output logic [DCCM_FDATA_WIDTH-1:0] rd_data_lo,
    output logic [DCCM_FDATA_WIDTH-1:0] rd_data_hi,
    output logic                        wb_empty,
    output logic [$clog2(WB_DEPTH):0]   wb_count
);

    localparam int PTR_W            = $clog2(WB_DEPTH);
    localparam int CNT_W            = PTR_W + 1;
    localparam int STALL_W          = $clog2(WB_STALL_MAX + 1);
    localparam int INDEX_BITS       = DCCM_BITS - DCCM_WIDTH_BITS - DCCM_BANK_BITS;
    localparam int DCCM_INDEX_DEPTH = 1 << INDEX_BITS;

    wb_entry_t                   wb_q [WB_DEPTH];
    logic [WB_DEPTH-1:0]         wb_vld;
    logic [PTR_W-1:0]            head_q, tail_q;
    logic [CNT_W-1:0]            count_q;
    logic [STALL_W-1:0]          stall_q;

    logic                        wr_acc, rd_acc, rd_unal, hd_unal, wb_busy, hd_blocked, drain;
    logic [DCCM_NUM_BANKS-1:0]   rd_en, hd_mask, drain_en;
    wb_entry_t                   hd;
    logic [DCCM_FDATA_WIDTH-1:0] bank_rdata [DCCM_NUM_BANKS];

    logic                        fwd_lo_hit, fwd_hi_hit, fwd_lo_hit_q, fwd_hi_hit_q;
    logic [DCCM_FDATA_WIDTH-1:0] fwd_lo_data, fwd_hi_data, fwd_lo_data_q, fwd_hi_data_q;
    logic [DCCM_BANK_BITS-1:0]   rd_bank_lo_q, rd_bank_hi_q;
    logic                        rd_unal_q;
    logic [DCCM_FDATA_WIDTH-1:0] rd_hi_raw;
    logic                        unused_offsets;

    assign wr_ready = count_q < CNT_W'(WB_DEPTH);
    assign rd_ready = stall_q != STALL_W'(WB_STALL_MAX);
    assign wr_acc   = wr_valid & wr_ready;
    assign rd_acc   = rd_valid & rd_ready;
    assign wb_busy  = count_q != '0;
    assign wb_empty = ~wb_busy;
    assign wb_count = count_q;
    assign hd       = wb_q[head_q];
    assign rd_unal  = dccm_bank(rd_addr_lo) != dccm_bank(rd_addr_hi);
    assign hd_unal  = dccm_bank(hd.addr_lo) != dccm_bank(hd.addr_hi);

    always_comb begin
        rd_en   = '0;
        hd_mask = '0;
        for (int b = 0; b < DCCM_NUM_BANKS; b++) begin
            rd_en[b]   = rd_acc & ((dccm_bank(rd_addr_lo) == DCCM_BANK_BITS'(b)) |
                                   (rd_unal & (dccm_bank(rd_addr_hi) == DCCM_BANK_BITS'(b))));
            hd_mask[b] = wb_busy & ((dccm_bank(hd.addr_lo) == DCCM_BANK_BITS'(b)) |
                                    (hd_unal & (dccm_bank(hd.addr_hi) == DCCM_BANK_BITS'(b))));
        end
    end

    // Reads win: the head drains only when none of its banks is being read
    assign hd_blocked = |(hd_mask & rd_en);
    assign drain      = wb_busy & ~hd_blocked;
    assign drain_en   = drain ? hd_mask : '0;

    for (genvar b = 0; b < DCCM_NUM_BANKS; b++) begin : g_bank
        logic [INDEX_BITS-1:0]       idx;
        logic [DCCM_FDATA_WIDTH-1:0] wdata;

        always_comb begin
            idx   = '0;
            wdata = '0;
            if (drain_en[b]) begin
                if (dccm_bank(hd.addr_lo) == DCCM_BANK_BITS'(b)) begin
                    idx   = dccm_index(hd.addr_lo);
                    wdata = hd.data_lo;
                end else begin
                    idx   = dccm_index(hd.addr_hi);
                    wdata = hd.data_hi;
                end
            end else if (dccm_bank(rd_addr_lo) == DCCM_BANK_BITS'(b)) begin
                idx = dccm_index(rd_addr_lo);
            end else begin
                idx = dccm_index(rd_addr_hi);
            end
        end

        lsu_dccm_bank #(
            .DEPTH (DCCM_INDEX_DEPTH),
            .WIDTH (DCCM_FDATA_WIDTH),
            .ADDR_W(INDEX_BITS)
        ) u_bank (
            .clk  (clk),
            .en   (rd_en[b] | drain_en[b]),
            .we   (drain_en[b]),
            .addr (idx),
            .wdata(wdata),
            .rdata(bank_rdata[b])
        );
    end

    // Scan oldest to youngest so the last match left standing is the youngest store
    always_comb begin
        logic [PTR_W-1:0] ptr;
        wb_entry_t        e;
        logic             e_unal;
        ptr         = head_q;
        e           = wb_q[head_q];
        e_unal      = 1'b0;
        fwd_lo_hit  = 1'b0;
        fwd_hi_hit  = 1'b0;
        fwd_lo_data = '0;
        fwd_hi_data = '0;
        for (int k = 0; k < WB_DEPTH; k++) begin
            ptr    = head_q + PTR_W'(k);
            e      = wb_q[ptr];
            e_unal = dccm_bank(e.addr_lo) != dccm_bank(e.addr_hi);
            if (wb_vld[ptr]) begin
                if (dccm_word(e.addr_lo) == dccm_word(rd_addr_lo)) begin
                    fwd_lo_hit  = 1'b1;
                    fwd_lo_data = e.data_lo;
                end
                if (e_unal && dccm_word(e.addr_hi) == dccm_word(rd_addr_lo)) begin
                    fwd_lo_hit  = 1'b1;
                    fwd_lo_data = e.data_hi;
                end
                if (dccm_word(e.addr_lo) == dccm_word(rd_addr_hi)) begin
                    fwd_hi_hit  = 1'b1;
                    fwd_hi_data = e.data_lo;
                end
                if (e_unal && dccm_word(e.addr_hi) == dccm_word(rd_addr_hi)) begin
                    fwd_hi_hit  = 1'b1;
                    fwd_hi_data = e.data_hi;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            wb_q[tail_q] <= '{addr_lo: wr_addr_lo, addr_hi: wr_addr_hi,
                              data_lo: wr_data_lo, data_hi: wr_data_hi};
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            stall_q       <= '0;
            wb_vld        <= '0;
            rd_data_valid <= 1'b0;
            fwd_lo_hit_q  <= 1'b0;
            fwd_hi_hit_q  <= 1'b0;
            fwd_lo_data_q <= '0;
            fwd_hi_data_q <= '0;
            rd_bank_lo_q  <= '0;
            rd_bank_hi_q  <= '0;
            rd_unal_q     <= 1'b0;
        end else begin
            rd_data_valid <= rd_acc;
            if (rd_acc) begin
                fwd_lo_hit_q  <= fwd_lo_hit;
                fwd_hi_hit_q  <= fwd_hi_hit;
                fwd_lo_data_q <= fwd_lo_data;
                fwd_hi_data_q <= fwd_hi_data;
                rd_bank_lo_q  <= dccm_bank(rd_addr_lo);
                rd_bank_hi_q  <= dccm_bank(rd_addr_hi);
                rd_unal_q     <= rd_unal;
            end
            if (wr_acc) begin
                tail_q         <= tail_q + PTR_W'(1);
                wb_vld[tail_q] <= 1'b1;
            end
            if (drain) begin
                head_q         <= head_q + PTR_W'(1);
                wb_vld[head_q] <= 1'b0;
            end
            count_q <= count_q + CNT_W'(wr_acc) - CNT_W'(drain);
            if (drain || !wb_busy) begin
                stall_q <= '0;
            end else if (hd_blocked && stall_q != STALL_W'(WB_STALL_MAX)) begin
                stall_q <= stall_q + STALL_W'(1);
            end
        end
    end

    assign rd_data_lo = fwd_lo_hit_q ? fwd_lo_data_q : bank_rdata[rd_bank_lo_q];
    assign rd_hi_raw  = fwd_hi_hit_q ? fwd_hi_data_q : bank_rdata[rd_bank_hi_q];
    assign rd_data_hi = rd_unal_q ? rd_hi_raw : rd_data_lo;

    // Byte-offset bits never select a word; fold them into a sink
    always_comb begin
        unused_offsets = ^rd_addr_lo[DCCM_WIDTH_BITS-1:0] ^ ^rd_addr_hi[DCCM_WIDTH_BITS-1:0];
        for (int k = 0; k < WB_DEPTH; k++) begin
            unused_offsets = unused_offsets ^ ^wb_q[k].addr_lo[DCCM_WIDTH_BITS-1:0]
                                            ^ ^wb_q[k].addr_hi[DCCM_WIDTH_BITS-1:0];
        end
    end

endmodule

// File: tb/tb_lsu_dccm_wbuf_mem.sv
// tb/tb_lsu_dccm_wbuf_mem.sv - directed self-checking bench for lsu_dccm_wbuf_mem
module tb_lsu_dccm_wbuf_mem;

    logic        clk;
    logic        rst_l;
    logic        wr_valid, wr_ready, rd_valid, rd_ready, rd_data_valid, wb_empty;
    logic [15:0] wr_addr_lo, wr_addr_hi, rd_addr_lo, rd_addr_hi;
    logic [38:0] wr_data_lo, wr_data_hi, rd_data_lo, rd_data_hi;
    logic [2:0]  wb_count;

    int errors = 0;
    int checks = 0;

    lsu_dccm_wbuf_mem dut (
        .clk          (clk),
        .rst_l        (rst_l),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_addr_lo   (wr_addr_lo),
        .wr_addr_hi   (wr_addr_hi),
        .wr_data_lo   (wr_data_lo),
        .wr_data_hi   (wr_data_hi),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .rd_addr_lo   (rd_addr_lo),
        .rd_addr_hi   (rd_addr_hi),
        .rd_data_valid(rd_data_valid),
        .rd_data_lo   (rd_data_lo),
        .rd_data_hi   (rd_data_hi),
        .wb_empty     (wb_empty),
        .wb_count     (wb_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cycle(input logic we, input logic [15:0] wal, input logic [15:0] wah,
                         input logic [38:0] wdl, input logic [38:0] wdh,
                         input logic re, input logic [15:0] ral, input logic [15:0] rah);
        wr_valid = we; wr_addr_lo = wal; wr_addr_hi = wah; wr_data_lo = wdl; wr_data_hi = wdh;
        rd_valid = re; rd_addr_lo = ral; rd_addr_hi = rah;
        step();
        wr_valid = 1'b0;
        rd_valid = 1'b0;
    endtask

    task automatic wait_empty();
        for (int i = 0; i < 20 && !wb_empty; i++) step();
        checks++;
        if (wb_empty !== 1'b1) begin errors++; $display("FAIL drain_timeout: wb_empty=%b required 1", wb_empty); end
    endtask

    task automatic test_reset();
        rst_l = 1'b0; wr_valid = 1'b0; rd_valid = 1'b0;
        wr_addr_lo = '0; wr_addr_hi = '0; wr_data_lo = '0; wr_data_hi = '0;
        rd_addr_lo = '0; rd_addr_hi = '0;
        step(); step();
        checks += 5;
        if (wr_ready !== 1'b1)      begin errors++; $display("FAIL reset_wr_ready: got %b required 1", wr_ready); end
        if (rd_ready !== 1'b1)      begin errors++; $display("FAIL reset_rd_ready: got %b required 1", rd_ready); end
        if (wb_empty !== 1'b1)      begin errors++; $display("FAIL reset_wb_empty: got %b required 1", wb_empty); end
        if (wb_count !== 3'd0)      begin errors++; $display("FAIL reset_wb_count: got %0d required 0", wb_count); end
        if (rd_data_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b required 0", rd_data_valid); end
        rst_l = 1'b1;
        step();
    endtask

    task automatic test_write_read();
        cycle(1, 16'h0100, 16'h0100, 39'h12345678, 39'h0, 0, 16'h0, 16'h0);
        checks += 2;
        if (wb_count !== 3'd1) begin errors++; $display("FAIL wr_count: got %0d required 1", wb_count); end
        if (wb_empty !== 1'b0) begin errors++; $display("FAIL wr_empty: got %b required 0", wb_empty); end
        wait_empty();
        cycle(0, 16'h0, 16'h0, 39'h0, 39'h0, 1, 16'h0100, 16'h0100);
        checks += 3;
        if (rd_data_valid !== 1'b1)       begin errors++; $display("FAIL rd_valid: got %b required 1", rd_data_valid); end
        if (rd_data_lo !== 39'h12345678) begin errors++; $display("FAIL rd_lo: got %h required 12345678", rd_data_lo); end
        if (rd_data_hi !== 39'h12345678) begin errors++; $display("FAIL rd_hi_aligned: got %h required 12345678", rd_data_hi); end
        step();
        checks++;
        if (rd_data_valid !== 1'b0) begin errors++; $display("FAIL rd_valid_pulse: got %b required 0", rd_data_valid); end
    endtask

    task automatic test_forward();
        cycle(1, 16'h0100, 16'h0100, 39'hA, 39'h0, 0, 16'h0, 16'h0);
        cycle(0, 16'h0, 16'h0, 39'h0, 39'h0, 1, 16'h0100, 16'h0100);
        checks += 2;
        if (rd_data_lo !== 39'hA) begin errors++; $display("FAIL fwd_data: got %h required a", rd_data_lo); end
        if (wb_count !== 3'd1)    begin errors++; $display("FAIL fwd_blocked_count: got %0d required 1", wb_count); end
        wait_empty();
        cycle(1, 16'h0100, 16'h0100, 39'hB, 39'h0, 1, 16'h0100, 16'h0100);
        checks++;
        if (rd_data_lo !== 39'hA) begin errors++; $display("FAIL same_cycle_old: got %h required a", rd_data_lo); end
        wait_empty();
        cycle(0, 16'h0, 16'h0, 39'h0, 39'h0, 1, 16'h0100, 16'h0100);
        checks++;
        if (rd_data_lo !== 39'hB) begin errors++; $display("FAIL same_cycle_later: got %h required b", rd_data_lo); end
    endtask

    task automatic test_unaligned();
        cycle(1, 16'h010C, 16'h0110, 39'h1111, 39'h2222, 0, 16'h0, 16'h0);
        step();
        checks++;
        if (wb_count !== 3'd0) begin errors++; $display("FAIL unal_atomic_drain: got %0d required 0", wb_count); end
        cycle(0, 16'h0, 16'h0, 39'h0, 39'h0, 1, 16'h010C, 16'h0110);
        checks += 2;
        if (rd_data_lo !== 39'h1111) begin errors++; $display("FAIL unal_lo: got %h required 1111", rd_data_lo); end
        if (rd_data_hi !== 39'h2222) begin errors++; $display("FAIL unal_hi: got %h required 2222", rd_data_hi); end
        cycle(0, 16'h0, 16'h0, 39'h0, 39'h0, 1, 16'h0110, 16'h0110);
        checks += 2;
        if (rd_data_lo !== 39'h2222) begin errors++; $display("FAIL bank0_lo: got %h required 2222", rd_data_lo); end
        if (rd_data_hi !== 39'h2222) begin errors++; $display("FAIL bank0_hi: got %h required 2222", rd_data_hi); end
        cycle(1, 16'h010C, 16'h0110, 39'h3333, 39'h4444, 0, 16'h0, 16'h0);
        cycle(0, 16'h0, 16'h0, 39'h0, 39'h0, 1, 16'h010C, 16'h0110);
        checks += 2;
        if (rd_data_lo !== 39'h3333) begin errors++; $display("FAIL unal_fwd_lo: got %h required 3333", rd_data_lo); end
        if (rd_data_hi !== 39'h4444) begin errors++; $display("FAIL unal_fwd_hi: got %h required 4444", rd_data_hi); end
        wait_empty();
    endtask

    task automatic test_stall();
        logic [15:0] addrs [4] = '{16'h0300, 16'h0340, 16'h0380, 16'h03C0};
        for (int i = 0; i < 4; i++)
            cycle(1, addrs[i], addrs[i], 39'h50 + 39'(i), 39'h0, 1, 16'h0000, 16'h0000);
        checks += 3;
        if (wr_ready !== 1'b0) begin errors++; $display("FAIL full_wr_ready: got %b required 0", wr_ready); end
        if (wb_count !== 3'd4) begin errors++; $display("FAIL full_count: got %0d required 4", wb_count); end
        if (rd_ready !== 1'b1) begin errors++; $display("FAIL stall3_rd_ready: got %b required 1", rd_ready); end
        cycle(0, 16'h0, 16'h0, 39'h0, 39'h0, 1, 16'h0000, 16'h0000);
        checks += 2;
        if (rd_ready !== 1'b0) begin errors++; $display("FAIL stall4_rd_ready: got %b required 0", rd_ready); end
        if (wb_count !== 3'd4) begin errors++; $display("FAIL stall4_count: got %0d required 4", wb_count); end
        cycle(0, 16'h0, 16'h0, 39'h0, 39'h0, 1, 16'h0000, 16'h0000);
        checks += 3;
        if (wb_count !== 3'd3)      begin errors++; $display("FAIL throttle_drain_count: got %0d required 3", wb_count); end
        if (rd_ready !== 1'b1)      begin errors++; $display("FAIL throttle_release: got %b required 1", rd_ready); end
        if (rd_data_valid !== 1'b0) begin errors++; $display("FAIL throttle_no_read: got %b required 0", rd_data_valid); end
        wait_empty();
        cycle(0, 16'h0, 16'h0, 39'h0, 39'h0, 1, 16'h03C0, 16'h03C0);
        checks++;
        if (rd_data_lo !== 39'h53) begin errors++; $display("FAIL stall_readback: got %h required 53", rd_data_lo); end
    endtask

    task automatic test_youngest();
        cycle(1, 16'h0200, 16'h0200, 39'h1, 39'h0, 1, 16'h0000, 16'h0000);
        cycle(1, 16'h0200, 16'h0200, 39'h2, 39'h0, 1, 16'h0000, 16'h0000);
        cycle(0, 16'h0, 16'h0, 39'h0, 39'h0, 1, 16'h0200, 16'h0200);
        checks += 2;
        if (rd_data_lo !== 39'h2) begin errors++; $display("FAIL youngest_fwd: got %h required 2", rd_data_lo); end
        if (wb_count !== 3'd2)    begin errors++; $display("FAIL youngest_count: got %0d required 2", wb_count); end
        wait_empty();
        cycle(0, 16'h0, 16'h0, 39'h0, 39'h0, 1, 16'h0200, 16'h0200);
        checks++;
        if (rd_data_lo !== 39'h2) begin errors++; $display("FAIL youngest_ram: got %h required 2", rd_data_lo); end
    endtask

    task automatic test_reset_mid();
        cycle(1, 16'h0300, 16'h0300, 39'h99, 39'h0, 1, 16'h0000, 16'h0000);
        cycle(1, 16'h0340, 16'h0340, 39'h98, 39'h0, 1, 16'h0000, 16'h0000);
        cycle(1, 16'h0380, 16'h0380, 39'h97, 39'h0, 1, 16'h0000, 16'h0000);
        checks += 2;
        if (wb_count !== 3'd3)      begin errors++; $display("FAIL pre_reset_count: got %0d required 3", wb_count); end
        if (rd_data_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_rd_valid: got %b required 1", rd_data_valid); end
        #2 rst_l = 1'b0;
        #1;
        checks += 4;
        if (wb_count !== 3'd0)      begin errors++; $display("FAIL midrst_count: got %0d required 0", wb_count); end
        if (wb_empty !== 1'b1)      begin errors++; $display("FAIL midrst_empty: got %b required 1", wb_empty); end
        if (rd_data_valid !== 1'b0) begin errors++; $display("FAIL midrst_rd_valid: got %b required 0", rd_data_valid); end
        if (wr_ready !== 1'b1)      begin errors++; $display("FAIL midrst_wr_ready: got %b required 1", wr_ready); end
        step();
        rst_l = 1'b1;
        step(); step();
        checks++;
        if (wb_count !== 3'd0) begin errors++; $display("FAIL post_rst_count: got %0d required 0", wb_count); end
        cycle(0, 16'h0, 16'h0, 39'h0, 39'h0, 1, 16'h0300, 16'h0300);
        checks++;
        if (rd_data_lo !== 39'h50) begin errors++; $display("FAIL discard_0300: got %h required 50", rd_data_lo); end
        cycle(0, 16'h0, 16'h0, 39'h0, 39'h0, 1, 16'h0340, 16'h0340);
        checks++;
        if (rd_data_lo !== 39'h51) begin errors++; $display("FAIL discard_0340: got %h required 51", rd_data_lo); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_forward();
        test_unaligned();
        test_stall();
        test_youngest();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
